// File: rtl/fp_pkg.sv
// Shared single-precision constants and the pre-normalisation record for the FP add/sub datapath.
package fp_pkg;

  localparam int ExpWidth   = 8;
  localparam int MantWidth  = 27;
  localparam int MaxShift   = MantWidth - 1;
  localparam int ShiftWidth = $clog2(MaxShift + 1);

  typedef struct packed {
    logic                  sign;
    logic [ExpWidth-1:0]   exp;
    logic [MantWidth-1:0]  mant;
    logic [ShiftWidth-1:0] shift;
    logic                  zero;
    logic                  denorm;
  } norm_prep_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero counter; an all-zero input reports Width.
module leading_zero_counter #(
  parameter int Width = 27
) (
  input  logic [Width-1:0]           data_i,
  output logic [$clog2(Width+1)-1:0] count_o
);

  localparam int CntWidth = $clog2(Width + 1);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = CntWidth'(Width);
    for (int i = 0; i < Width; i++) begin
      if (data_i[i]) begin
        count_o = CntWidth'(Width - 1 - i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/fp_norm_prep_stage.sv
// Two-stage pre-normalisation after the mantissa adder: leading-zero count, then a shift
// clamped so the exponent never falls below the minimum normal exponent.
module fp_norm_prep_stage #(
  parameter int MantWidth = fp_pkg::MantWidth,
  parameter int ExpWidth  = fp_pkg::ExpWidth,
  parameter int MaxShift  = MantWidth - 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          sign_i,
  input  logic [ExpWidth-1:0]           exp_i,
  input  logic [MantWidth-1:0]          mant_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          sign_o,
  output logic [MantWidth-1:0]          mant_o,
  output logic [$clog2(MaxShift+1)-1:0] shift_o,
  output logic [ExpWidth-1:0]           exp_o,
  output logic                          zero_o,
  output logic                          denorm_o
);

  localparam int ShiftWidth = $clog2(MaxShift + 1);
  localparam int LzWidth    = $clog2(MantWidth + 1);

  logic                  v1_q, v1_d, v2_q, v2_d;
  logic                  sign1_q, sign1_d;
  logic [ExpWidth-1:0]   exp1_q, exp1_d;
  logic [MantWidth-1:0]  mant1_q, mant1_d;
  logic [LzWidth-1:0]    lz1_q, lz1_d, lz_s;
  logic                  adv1_s, adv2_s, load1_s, load2_s;
  logic [ExpWidth-1:0]   exp_m1_s, lz_ext_s;
  fp_pkg::norm_prep_t    s2_q, s2_d, s2_calc_s;

  leading_zero_counter #(.Width(MantWidth)) u_lzc (
    .data_i (mant_i),
    .count_o(lz_s)
  );

  // Stage advance and load enables; flush suppresses every load.
  always_comb begin
    adv2_s  = ~v2_q | ready_i;
    adv1_s  = ~v1_q | adv2_s;
    load1_s = valid_i & adv1_s & ~flush_i;
    load2_s = v1_q & adv2_s & ~flush_i;
  end

  assign ready_o = adv1_s;

  // Valid bits move forward whenever the receiving stage advances.
  always_comb begin
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      v1_d = adv1_s ? valid_i : v1_q;
      v2_d = adv2_s ? v1_q : v2_q;
    end
  end

  // S1 data captures only on an accepted handshake.
  always_comb begin
    if (load1_s) begin
      sign1_d = sign_i;
      exp1_d  = exp_i;
      mant1_d = mant_i;
      lz1_d   = lz_s;
    end else begin
      sign1_d = sign1_q;
      exp1_d  = exp1_q;
      mant1_d = mant1_q;
      lz1_d   = lz1_q;
    end
  end

  // Clamp the shift to exp-1 so the result exponent bottoms out at 1; excess zeros mean subnormal.
  always_comb begin
    exp_m1_s         = exp1_q - ExpWidth'(1);
    lz_ext_s         = ExpWidth'(lz1_q);
    s2_calc_s.sign   = sign1_q;
    s2_calc_s.mant   = mant1_q;
    s2_calc_s.zero   = (mant1_q == {MantWidth{1'b0}});
    s2_calc_s.shift  = {ShiftWidth{1'b0}};
    s2_calc_s.exp    = {ExpWidth{1'b0}};
    s2_calc_s.denorm = 1'b0;
    if (s2_calc_s.zero) begin
      s2_calc_s.denorm = 1'b0;
    end else if (exp1_q == {ExpWidth{1'b0}}) begin
      s2_calc_s.denorm = 1'b1;
    end else if (lz_ext_s > exp_m1_s) begin
      s2_calc_s.shift  = ShiftWidth'(exp_m1_s);
      s2_calc_s.exp    = exp1_q - exp_m1_s;
      s2_calc_s.denorm = 1'b1;
    end else begin
      s2_calc_s.shift  = ShiftWidth'(lz1_q);
      s2_calc_s.exp    = exp1_q - lz_ext_s;
      s2_calc_s.denorm = 1'b0;
    end
  end

  // S2 holds its contents under backpressure and while empty.
  always_comb begin
    if (load2_s) begin
      s2_d = s2_calc_s;
    end else begin
      s2_d = s2_q;
    end
  end

  // Pipeline state; asynchronous reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sign1_q <= 1'b0;
      exp1_q  <= {ExpWidth{1'b0}};
      mant1_q <= {MantWidth{1'b0}};
      lz1_q   <= {LzWidth{1'b0}};
      s2_q    <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sign1_q <= sign1_d;
      exp1_q  <= exp1_d;
      mant1_q <= mant1_d;
      lz1_q   <= lz1_d;
      s2_q    <= s2_d;
    end
  end

  assign valid_o  = v2_q;
  assign sign_o   = s2_q.sign;
  assign mant_o   = s2_q.mant;
  assign shift_o  = s2_q.shift;
  assign exp_o    = s2_q.exp;
  assign zero_o   = s2_q.zero;
  assign denorm_o = s2_q.denorm;

endmodule

// File: tb/tb_fp_norm_prep_stage.sv
// Directed bench for fp_norm_prep_stage: latency, clamp boundaries, backpressure, flush, async reset.
module tb_fp_norm_prep_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, valid_i, ready_o, sign_i, ready_i;
  logic [7:0]  exp_i, exp_o;
  logic [26:0] mant_i, mant_o;
  logic        valid_o, sign_o, zero_o, denorm_o;
  logic [4:0]  shift_o;

  int n_checks = 0;
  int n_errors = 0;

  fp_norm_prep_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .valid_o(valid_o), .ready_i(ready_i),
    .sign_o(sign_o), .mant_o(mant_o), .shift_o(shift_o), .exp_o(exp_o), .zero_o(zero_o),
    .denorm_o(denorm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [26:0] m);
    valid_i = v;
    sign_i  = s;
    exp_i   = e;
    mant_i  = m;
  endtask

  task automatic check_out(input string tag, input logic s, input logic [26:0] m,
                           input logic [4:0] sh, input logic [7:0] e, input logic z, input logic d);
    chk({tag, ".valid"},  32'(valid_o),  32'd1);
    chk({tag, ".sign"},   32'(sign_o),   32'(s));
    chk({tag, ".mant"},   32'(mant_o),   32'(m));
    chk({tag, ".shift"},  32'(shift_o),  32'(sh));
    chk({tag, ".exp"},    32'(exp_o),    32'(e));
    chk({tag, ".zero"},   32'(zero_o),   32'(z));
    chk({tag, ".denorm"}, 32'(denorm_o), 32'(d));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".valid"},  32'(valid_o),  32'd0);
    chk({tag, ".ready"},  32'(ready_o),  32'd1);
    chk({tag, ".sign"},   32'(sign_o),   32'd0);
    chk({tag, ".mant"},   32'(mant_o),   32'd0);
    chk({tag, ".shift"},  32'(shift_o),  32'd0);
    chk({tag, ".exp"},    32'(exp_o),    32'd0);
    chk({tag, ".zero"},   32'(zero_o),   32'd0);
    chk({tag, ".denorm"}, 32'(denorm_o), 32'd0);
  endtask

  // Offer one operand for a single cycle, then wait out the second pipeline cycle.
  task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m);
    drive(1'b1, s, e, m);
    step();
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    step();
  endtask

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    #12;
    check_cleared("reset");
    rst_ni = 1'b1;

    // Latency: nothing after one edge, result after the second.
    drive(1'b1, 1'b0, 8'd100, 27'h0400000);
    step();
    chk("lat1.valid", 32'(valid_o), 32'd0);
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    step();
    check_out("lat2", 1'b0, 27'h0400000, 5'd4, 8'd96, 1'b0, 1'b0);

    send(1'b0, 8'd10, 27'h0000001);
    check_out("clamp", 1'b0, 27'h0000001, 5'd9, 8'd1, 1'b0, 1'b1);
    send(1'b1, 8'd5, 27'h4000000);
    check_out("msb", 1'b1, 27'h4000000, 5'd0, 8'd5, 1'b0, 1'b0);
    send(1'b0, 8'd77, 27'h0000000);
    check_out("zero", 1'b0, 27'h0000000, 5'd0, 8'd0, 1'b1, 1'b0);
    send(1'b1, 8'd0, 27'h0000100);
    check_out("exp0", 1'b1, 27'h0000100, 5'd0, 8'd0, 1'b0, 1'b1);
    send(1'b0, 8'd16, 27'h0000800);
    check_out("edge_eq", 1'b0, 27'h0000800, 5'd15, 8'd1, 1'b0, 1'b0);
    send(1'b0, 8'd1, 27'h2000000);
    check_out("exp1", 1'b0, 27'h2000000, 5'd0, 8'd1, 1'b0, 1'b1);
    send(1'b1, 8'd200, 27'h0000800);
    check_out("big", 1'b1, 27'h0000800, 5'd15, 8'd185, 1'b0, 1'b0);
    step();
    chk("drain.valid", 32'(valid_o), 32'd0);

    // Backpressure with four operands A..D.
    ready_i = 1'b1;
    drive(1'b1, 1'b0, 8'd50, 27'h4000000);
    step();
    ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'd50, 27'h1000000);
    chk("bp.ready_b", 32'(ready_o), 32'd1);
    step();
    check_out("bp.a0", 1'b0, 27'h4000000, 5'd0, 8'd50, 1'b0, 1'b0);
    chk("bp.full", 32'(ready_o), 32'd0);
    drive(1'b1, 1'b0, 8'd50, 27'h0010000);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("bp.hold", 1'b0, 27'h4000000, 5'd0, 8'd50, 1'b0, 1'b0);
      chk("bp.stall", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    step();
    check_out("bp.b", 1'b0, 27'h1000000, 5'd2, 8'd48, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd50, 27'h0000400);
    step();
    check_out("bp.c", 1'b0, 27'h0010000, 5'd10, 8'd40, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    step();
    check_out("bp.d", 1'b0, 27'h0000400, 5'd16, 8'd34, 1'b0, 1'b0);
    step();
    chk("bp.end", 32'(valid_o), 32'd0);

    // Flush with both stages full and a new operand offered in the same cycle.
    ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'd60, 27'h0200000);
    step();
    drive(1'b1, 1'b0, 8'd61, 27'h0100000);
    step();
    chk("fl.full", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 1'b0, 8'd62, 27'h0080000);
    step();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    chk("fl.valid", 32'(valid_o), 32'd0);
    chk("fl.ready", 32'(ready_o), 32'd1);
    step();
    chk("fl.gone1", 32'(valid_o), 32'd0);
    step();
    chk("fl.gone2", 32'(valid_o), 32'd0);
    send(1'b0, 8'd30, 27'h0040000);
    check_out("fl.after", 1'b0, 27'h0040000, 5'd8, 8'd22, 1'b0, 1'b0);

    // Asynchronous reset between edges with both stages occupied.
    ready_i = 1'b0;
    drive(1'b1, 1'b1, 8'd90, 27'h0020000);
    step();
    drive(1'b1, 1'b1, 8'd91, 27'h0010000);
    step();
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_cleared("arst");
    #2;
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 8'd40, 27'h0008000);
    step();
    chk("arst.lat1", 32'(valid_o), 32'd0);
    drive(1'b0, 1'b0, 8'd0, 27'd0);
    step();
    check_out("arst.first", 1'b1, 27'h0008000, 5'd11, 8'd29, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
